// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch/jump flush,
// multi-cycle data-memory waits with a sticky bus-timeout halt and stall counter.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_IDEX_MemRead,
    input  logic [4:0]  i_IDEX_RtAddr,
    input  logic [4:0]  i_IFID_RsAddr,
    input  logic [4:0]  i_IFID_RtAddr,
    input  logic        i_ID_UsesRt,
    input  logic        i_ID_Jump,
    input  logic        i_EX_BranchTaken,
    input  logic        i_EXMEM_MemAccess,
    input  logic        i_Mem_Ready,
    output logic        o_Mem_Req,
    output logic        o_PC_Write,
    output logic        o_IFID_Write,
    output logic        o_IDEX_Write,
    output logic        o_EXMEM_Write,
    output logic        o_MEMWB_Write,
    output logic        o_IFID_Flush,
    output logic        o_IDEX_Flush,
    output logic        o_EXMEM_Flush,
    output logic        o_MEMWB_Flush,
    output logic        o_Mem_Timeout,
    output logic [15:0] o_Stall_Count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_nxt;
    logic             r_timeout;
    logic [15:0]      r_stall_cnt;

    logic w_load_use;
    logic w_hz_en;
    logic w_to_halt;

    assign w_load_use = i_IDEX_MemRead && (i_IDEX_RtAddr != 5'd0) &&
                        ((i_IDEX_RtAddr == i_IFID_RsAddr) ||
                         (i_ID_UsesRt && (i_IDEX_RtAddr == i_IFID_RtAddr)));

    always_comb begin
        w_next        = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_hz_en       = 1'b0;
        w_to_halt     = 1'b0;
        o_Mem_Req     = 1'b0;
        o_PC_Write    = 1'b1;
        o_IFID_Write  = 1'b1;
        o_IDEX_Write  = 1'b1;
        o_EXMEM_Write = 1'b1;
        o_MEMWB_Write = 1'b1;
        o_IFID_Flush  = 1'b0;
        o_IDEX_Flush  = 1'b0;
        o_EXMEM_Flush = 1'b0;
        o_MEMWB_Flush = 1'b0;
        if (!reset) begin
            case (r_state)
                RUN: begin
                    o_Mem_Req = i_EXMEM_MemAccess;
                    if (i_EXMEM_MemAccess && !i_Mem_Ready) begin
                        w_next     = MEM_WAIT;
                        w_wait_nxt = CNT_W'(1);
                    end else begin
                        w_hz_en = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    o_Mem_Req = i_EXMEM_MemAccess;
                    if (!i_Mem_Ready) begin
                        w_wait_nxt = r_wait_cnt + 1'b1;
                        if (r_wait_cnt == TIMEOUT_VAL) begin
                            w_next    = HALT;
                            w_to_halt = 1'b1;
                        end
                    end else begin
                        w_hz_en    = 1'b1;
                        w_next     = RUN;
                        w_wait_nxt = '0;
                    end
                end
                default: begin
                    o_PC_Write    = 1'b0;
                    o_IFID_Write  = 1'b0;
                    o_IDEX_Write  = 1'b0;
                    o_EXMEM_Write = 1'b0;
                    o_MEMWB_Write = 1'b0;
                end
            endcase
            // Frozen pipe: hazard inputs are ignored until memory releases.
            if (r_state != HALT && !w_hz_en) begin
                o_PC_Write    = 1'b0;
                o_IFID_Write  = 1'b0;
                o_IDEX_Write  = 1'b0;
                o_EXMEM_Write = 1'b0;
                o_MEMWB_Write = 1'b0;
                o_MEMWB_Flush = 1'b1;
            end
            if (w_hz_en) begin
                if (i_EX_BranchTaken) begin
                    o_IFID_Flush = 1'b1;
                    o_IDEX_Flush = 1'b1;
                end else if (w_load_use) begin
                    o_PC_Write   = 1'b0;
                    o_IFID_Write = 1'b0;
                    o_IDEX_Flush = 1'b1;
                end else if (i_ID_Jump) begin
                    o_IFID_Flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_nxt;
            if (w_to_halt) begin
                r_timeout <= 1'b1;
            end
            if (!o_PC_Write && r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign o_Mem_Timeout = r_timeout;
    assign o_Stall_Count = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected output vectors are queued
// as each step is driven and checked mid-cycle with immediate assertions.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        IDEX_MemRead;
    logic [4:0]  IDEX_RtAddr;
    logic [4:0]  IFID_RsAddr;
    logic [4:0]  IFID_RtAddr;
    logic        ID_UsesRt;
    logic        ID_Jump;
    logic        EX_BranchTaken;
    logic        EXMEM_MemAccess;
    logic        Mem_Ready;
    logic        Mem_Req;
    logic        PC_Write;
    logic        IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write;
    logic        IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush;
    logic        Mem_Timeout;
    logic [15:0] Stall_Count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        logic [10:0] outs;
        int          cnt;
    } exp_t;

    exp_t sb[$];

    // {req, pc, ifw, idw, exw, mww, iff, idf, exf, mwf, timeout}
    localparam logic [10:0] NORM  = 11'b0_1_1111_0000_0;
    localparam logic [10:0] NREQ  = 11'b1_1_1111_0000_0;
    localparam logic [10:0] MSTL  = 11'b1_0_0000_0001_0;
    localparam logic [10:0] LUSE  = 11'b0_0_0111_0100_0;
    localparam logic [10:0] BRAN  = 11'b0_1_1111_1100_0;
    localparam logic [10:0] JUMP  = 11'b0_1_1111_1000_0;
    localparam logic [10:0] HALTV = 11'b0_0_0000_0000_1;
    localparam logic [10:0] RBRAN = 11'b1_1_1111_1100_0;
    localparam logic [10:0] RLUSE = 11'b1_0_0111_0100_0;
    localparam logic [10:0] RSTTO = 11'b0_1_1111_0000_1;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W(8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .i_IDEX_MemRead    (IDEX_MemRead),
        .i_IDEX_RtAddr     (IDEX_RtAddr),
        .i_IFID_RsAddr     (IFID_RsAddr),
        .i_IFID_RtAddr     (IFID_RtAddr),
        .i_ID_UsesRt       (ID_UsesRt),
        .i_ID_Jump         (ID_Jump),
        .i_EX_BranchTaken  (EX_BranchTaken),
        .i_EXMEM_MemAccess (EXMEM_MemAccess),
        .i_Mem_Ready       (Mem_Ready),
        .o_Mem_Req         (Mem_Req),
        .o_PC_Write        (PC_Write),
        .o_IFID_Write      (IFID_Write),
        .o_IDEX_Write      (IDEX_Write),
        .o_EXMEM_Write     (EXMEM_Write),
        .o_MEMWB_Write     (MEMWB_Write),
        .o_IFID_Flush      (IFID_Flush),
        .o_IDEX_Flush      (IDEX_Flush),
        .o_EXMEM_Flush     (EXMEM_Flush),
        .o_MEMWB_Flush     (MEMWB_Flush),
        .o_Mem_Timeout     (Mem_Timeout),
        .o_Stall_Count     (Stall_Count)
    );

    always #5 clk = ~clk;

    task automatic check_out();
        exp_t        e;
        logic [10:0] got;
        e   = sb.pop_front();
        got = {Mem_Req, PC_Write, IFID_Write, IDEX_Write, EXMEM_Write,
               MEMWB_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush,
               MEMWB_Flush, Mem_Timeout};
        tests++;
        assert (got === e.outs) else begin
            fails++;
            $error("FAIL %s outs got=%b exp=%b", e.tag, got, e.outs);
        end
        tests++;
        assert (Stall_Count === 16'(e.cnt)) else begin
            fails++;
            $error("FAIL %s stall_cnt got=%0d exp=%0d",
                   e.tag, Stall_Count, e.cnt);
        end
    endtask

    task automatic step(
        input string       tag,
        input logic        rst,
        input logic        mrd,
        input logic [4:0]  lrt,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic        urt,
        input logic        jmp,
        input logic        br,
        input logic        macc,
        input logic        rdy,
        input logic [10:0] eo,
        input int          ec
    );
        reset           = rst;
        IDEX_MemRead    = mrd;
        IDEX_RtAddr     = lrt;
        IFID_RsAddr     = rs;
        IFID_RtAddr     = rt;
        ID_UsesRt       = urt;
        ID_Jump         = jmp;
        EX_BranchTaken  = br;
        EXMEM_MemAccess = macc;
        Mem_Ready       = rdy;
        sb.push_back('{tag, eo, ec});
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   tag        rst mrd lrt rs  rt  urt jmp br macc rdy  exp    cnt
        step("rst",     1,  0,  0,  0,  0,  0,  0,  0, 0,   0,   NORM,  0);
        step("idle",    0,  0,  0,  0,  0,  0,  0,  0, 0,   0,   NORM,  0);
        step("t1_lu",   0,  1,  8,  8,  0,  0,  0,  0, 0,   0,   LUSE,  0);
        step("t1_post", 0,  0,  0,  0,  0,  0,  0,  0, 0,   0,   NORM,  1);
        step("t1_r0",   0,  1,  0,  0,  0,  0,  0,  0, 0,   0,   NORM,  1);
        step("lu_rt",   0,  1,  9,  3,  9,  1,  0,  0, 0,   0,   LUSE,  1);
        step("lu_nort", 0,  1,  9,  3,  9,  0,  0,  0, 0,   0,   NORM,  2);
        step("t2_br",   0,  1,  8,  8,  0,  0,  0,  1, 0,   0,   BRAN,  2);
        step("jump",    0,  0,  0,  0,  0,  0,  1,  0, 0,   0,   JUMP,  2);
        step("lu_jmp",  0,  1,  8,  8,  0,  0,  1,  0, 0,   0,   LUSE,  2);
        step("zwait",   0,  0,  0,  0,  0,  0,  0,  0, 1,   1,   NREQ,  3);
        step("t3_w0",   0,  0,  0,  0,  0,  0,  0,  0, 1,   0,   MSTL,  3);
        step("t3_w1",   0,  0,  0,  0,  0,  0,  0,  1, 1,   0,   MSTL,  4);
        step("t3_w2",   0,  1,  8,  8,  0,  0,  1,  0, 1,   0,   MSTL,  5);
        step("t3_rel",  0,  0,  0,  0,  0,  0,  0,  0, 1,   1,   NREQ,  6);
        step("t3_run",  0,  0,  0,  0,  0,  0,  0,  0, 0,   0,   NORM,  6);
        step("t5_w0",   0,  0,  0,  0,  0,  0,  0,  0, 1,   0,   MSTL,  6);
        step("t5_w1",   0,  0,  0,  0,  0,  0,  0,  1, 1,   0,   MSTL,  7);
        step("t5_rel",  0,  0,  0,  0,  0,  0,  0,  1, 1,   1,   RBRAN, 8);
        step("t5_run",  0,  0,  0,  0,  0,  0,  0,  0, 0,   0,   NORM,  8);
        step("rlu_w0",  0,  0,  0,  0,  0,  0,  0,  0, 1,   0,   MSTL,  8);
        step("rlu_rel", 0,  1,  8,  8,  0,  0,  0,  0, 1,   1,   RLUSE, 9);
        step("rlu_run", 0,  0,  0,  0,  0,  0,  0,  0, 0,   0,   NORM,  10);
        step("t4_w0",   0,  0,  0,  0,  0,  0,  0,  0, 1,   0,   MSTL,  10);
        step("t4_w1",   0,  0,  0,  0,  0,  0,  0,  0, 1,   0,   MSTL,  11);
        step("t4_w2",   0,  0,  0,  0,  0,  0,  0,  0, 1,   0,   MSTL,  12);
        step("t4_w3",   0,  0,  0,  0,  0,  0,  0,  0, 1,   0,   MSTL,  13);
        step("t4_w4",   0,  0,  0,  0,  0,  0,  0,  0, 1,   0,   MSTL,  14);
        step("t4_halt", 0,  0,  0,  0,  0,  0,  0,  0, 1,   0,   HALTV, 15);
        step("t4_rdy",  0,  1,  8,  8,  0,  0,  1,  1, 1,   1,   HALTV, 16);
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
        end
        #1;
        step("t6_sat",  0,  0,  0,  0,  0,  0,  0,  0, 1,   0,   HALTV, 65535);
        step("t6_hold", 0,  0,  0,  0,  0,  0,  0,  0, 1,   0,   HALTV, 65535);
        step("t4_rst",  1,  0,  0,  0,  0,  0,  0,  0, 1,   0,   RSTTO, 65535);
        step("t4_clr",  0,  0,  0,  0,  0,  0,  0,  0, 0,   0,   NORM,  0);
        step("t4_run",  0,  0,  0,  0,  0,  0,  0,  0, 1,   1,   NREQ,  0);
        step("rw_w0",   0,  0,  0,  0,  0,  0,  0,  0, 1,   0,   MSTL,  0);
        step("rw_rst",  1,  0,  0,  0,  0,  0,  0,  0, 1,   0,   NORM,  1);
        step("rw_run",  0,  0,  0,  0,  0,  0,  0,  0, 1,   1,   NREQ,  0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
